pipeline_stall_ctrl: RTL and testbench
======================================

Name: pipeline_stall_ctrl

Overview:
Central stall/flush sequencer for the 5-stage pipeline. It consumes the hazard unit's bubble request, the execute stage's branch-taken flag and the data-memory request/ack handshake. It drives per-stage register enables and flushes for the PC, fd, dx, xm and mw registers. A registered FSM decides whether the pipeline advances, holds with a bubble into xm, waits on memory, or squashes wrong-path instructions.

Parameters:
MEM_TIMEOUT, 16, cycles in MEM_WAIT without ack before mem_timeout_o is set (>=1)
MAX_BUBBLE, 2, consecutive bubble cycles tolerated before hazard_err_o is set (>=1)
CNT_W, 32, width of the optional stall counter

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  synchronous, active-high reset
bubble_i  in  1  load/store-use bubble request from hazard_detection
branch_taken_i  in  1  branch resolved taken in dx/execute this cycle
mem_req_i  in  1  xm stage holds a valid load/store this cycle
mem_ack_i  in  1  data memory completes the xm access this cycle
pc_en_o  out  1  PC register update enable
fd_en_o  out  1  fd register enable
fd_flush_o  out  1  load NOP into fd
dx_en_o  out  1  dx register enable
dx_flush_o  out  1  load NOP into dx
xm_en_o  out  1  xm register enable
xm_flush_o  out  1  load NOP into xm
mw_flush_o  out  1  load NOP into mw (mw always clocks)
mem_timeout_o  out  1  sticky: memory ack overdue
hazard_err_o  out  1  sticky: bubble persisted too long
stall_cnt_o  out  CNT_W  stall-cycle count (STALL_COUNTER_EN only; else tied 0)

Behaviour:
- FSM states: RUN, MEM_WAIT, FLUSH. State is registered. Outputs are combinational from state and inputs (Mealy).
- Reset, evaluated at the clock edge: state=RUN, pending_flush=0, bubble_run=0, timeout counter=0, mem_timeout_o=0, hazard_err_o=0, stall_cnt_o=0.
- While reset is high, outputs are forced to: all *_en_o=0, all *_flush_o=1.
- Default output set (advance): all enables 1, all flushes 0.
- RUN, priority high to low:
  1. mem_req_i && !mem_ack_i -> pc/fd/dx/xm enables 0, mw_flush_o=1. If branch_taken_i, set pending_flush. Next state MEM_WAIT.
  2. branch_taken_i -> advance with fd_flush_o=1 and dx_flush_o=1. Next state FLUSH.
  3. bubble_i -> pc_en_o=0, fd_en_o=0, dx_en_o=0, xm_flush_o=1. Increment bubble_run. If bubble_run reaches MAX_BUBBLE, set hazard_err_o. Stay in RUN.
  4. Otherwise -> advance, clear bubble_run.
  - A request with mem_ack_i in the same cycle is a single-cycle access: it is treated as no stall.
- MEM_WAIT:
  - !mem_ack_i -> hold as in RUN case 1; timeout counter increments. On reaching MEM_TIMEOUT, set mem_timeout_o and saturate the counter; keep waiting.
  - mem_ack_i -> advance; clear timeout counter. If pending_flush, also assert fd_flush_o and dx_flush_o, clear pending_flush, and go to FLUSH. Otherwise go to RUN.
  - bubble_i and branch_taken_i are ignored in MEM_WAIT because dx is frozen and pending_flush already holds any branch.
- FLUSH:
  - Lasts exactly one cycle; dx holds a NOP, so bubble_i and branch_taken_i are ignored.
  - mem_req_i && !mem_ack_i -> behave as RUN case 1 and enter MEM_WAIT. Otherwise advance and go to RUN.
- Sticky flags clear only on reset.
- bubble_run saturates at MAX_BUBBLE.

Optional Feature:
STALL_COUNTER_EN
- Defined: stall_cnt_o increments by 1 in every cycle where pc_en_o=0 (bubble or memory hold). It wraps modulo 2^CNT_W and resets to 0.
- Undefined: no counter register is built; stall_cnt_o is constant 0.

Test Plan:
- Reset held 3 cycles, then released -> during reset all enables 0 and flushes 1; first cycle after release, all enables 1, flushes 0, state RUN.
- bubble_i high for 1 cycle in RUN -> that cycle pc_en_o=fd_en_o=dx_en_o=0 and xm_flush_o=1; next cycle advance; hazard_err_o stays 0. Hold bubble_i for 2 cycles (MAX_BUBBLE=2) -> hazard_err_o=1 and remains 1.
- mem_req_i=1 with mem_ack_i arriving 3 cycles later -> 3 hold cycles (pc_en_o=0, mw_flush_o=1), advance on the ack cycle, then RUN. With STALL_COUNTER_EN, stall_cnt_o=3.
- mem_req_i=1 and branch_taken_i=1 in the same RUN cycle, ack 2 cycles later -> on the ack cycle fd_flush_o=dx_flush_o=1, next state FLUSH, then RUN; pending_flush cleared.
- branch_taken_i with bubble_i in the same RUN cycle -> flush wins: fd_flush_o=dx_flush_o=1, pc_en_o=1, xm_flush_o=0. In the following FLUSH cycle, bubble_i=1 is ignored (pc_en_o=1).
- mem_ack_i withheld 20 cycles (MEM_TIMEOUT=16) -> mem_timeout_o rises after 16 wait cycles and stays high after the ack; reset asserted mid-wait -> state RUN, all flags 0.

Source files
------------

// File: rtl/pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Central stall/flush sequencer for the 5-stage pipeline (PC, fd, dx, xm, mw).
// A registered three-state FSM (RUN, MEM_WAIT, FLUSH) decides each cycle
// whether the pipeline:
//   - advances,
//   - holds with a bubble into xm,
//   - waits on data memory, or
//   - squashes wrong-path instructions.
// Stage controls are Mealy outputs derived from the current state and inputs.
//
// Optional feature macro: STALL_COUNTER_EN
//   When defined, stall_cnt_o counts the cycles in which pc_en_o is low.
//   When undefined, stall_cnt_o is tied to zero.
//
// Parameters:
//   MEM_TIMEOUT  MEM_WAIT cycles without an ack before mem_timeout_o is set (>=1)
//   MAX_BUBBLE   consecutive bubble cycles before hazard_err_o is set (>=1)
//   CNT_W        width of the optional stall counter
//
// Ports:
//   clk             pipeline clock, rising edge
//   reset           synchronous, active-high reset
//   bubble_i        load/store-use bubble request from hazard detection
//   branch_taken_i  branch resolved taken in dx this cycle
//   mem_req_i       xm holds a valid load/store this cycle
//   mem_ack_i       data memory completes the xm access this cycle
//   pc_en_o         PC update enable
//   fd_en_o         fd register enable
//   fd_flush_o      load a NOP into fd
//   dx_en_o         dx register enable
//   dx_flush_o      load a NOP into dx
//   xm_en_o         xm register enable
//   xm_flush_o      load a NOP into xm
//   mw_flush_o      load a NOP into mw (mw always clocks)
//   mem_timeout_o   sticky: memory ack overdue
//   hazard_err_o    sticky: bubble persisted too long
//   stall_cnt_o     stall-cycle count (zero unless STALL_COUNTER_EN is defined)
// ---------------------------------------------------------------------------
module pipeline_stall_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int MAX_BUBBLE  = 2,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             bubble_i,
  input  logic             branch_taken_i,
  input  logic             mem_req_i,
  input  logic             mem_ack_i,
  output logic             pc_en_o,
  output logic             fd_en_o,
  output logic             fd_flush_o,
  output logic             dx_en_o,
  output logic             dx_flush_o,
  output logic             xm_en_o,
  output logic             xm_flush_o,
  output logic             mw_flush_o,
  output logic             mem_timeout_o,
  output logic             hazard_err_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam int TW = $clog2(MEM_TIMEOUT + 1);
  localparam int BW = $clog2(MAX_BUBBLE + 1);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  state_t          state_r, state_nxt_s;
  logic            pending_flush_r, pending_flush_nxt_s;
  logic [BW-1:0]   bubble_run_r, bubble_run_nxt_s;
  logic [TW-1:0]   tmo_cnt_r, tmo_cnt_nxt_s;
  logic            mem_timeout_r, hazard_err_r;
  logic            set_tmo_s, set_haz_s;
  logic            hold_s;

  logic pc_en_s, fd_en_s, fd_flush_s, dx_en_s, dx_flush_s;
  logic xm_en_s, xm_flush_s, mw_flush_s;

  // An access acked in the same cycle it is requested completes without a stall.
  assign hold_s = mem_req_i && !mem_ack_i;

  // Next-state, bookkeeping and stage-control decode.
  always_comb begin
    pc_en_s             = 1'b1;
    fd_en_s             = 1'b1;
    fd_flush_s          = 1'b0;
    dx_en_s             = 1'b1;
    dx_flush_s          = 1'b0;
    xm_en_s             = 1'b1;
    xm_flush_s          = 1'b0;
    mw_flush_s          = 1'b0;
    state_nxt_s         = state_r;
    pending_flush_nxt_s = pending_flush_r;
    bubble_run_nxt_s    = bubble_run_r;
    tmo_cnt_nxt_s       = tmo_cnt_r;
    set_tmo_s           = 1'b0;
    set_haz_s           = 1'b0;

    case (state_r)
      RUN: begin
        if (hold_s) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          dx_en_s     = 1'b0;
          xm_en_s     = 1'b0;
          mw_flush_s  = 1'b1;
          state_nxt_s = MEM_WAIT;
          // A branch resolved under the memory stall is replayed on the ack.
          if (branch_taken_i) begin
            pending_flush_nxt_s = 1'b1;
          end else begin
            pending_flush_nxt_s = pending_flush_r;
          end
        end else if (branch_taken_i) begin
          fd_flush_s  = 1'b1;
          dx_flush_s  = 1'b1;
          state_nxt_s = FLUSH;
        end else if (bubble_i) begin
          pc_en_s    = 1'b0;
          fd_en_s    = 1'b0;
          dx_en_s    = 1'b0;
          xm_flush_s = 1'b1;
          if (bubble_run_r != BW'(MAX_BUBBLE)) begin
            bubble_run_nxt_s = bubble_run_r + BW'(1);
          end else begin
            bubble_run_nxt_s = bubble_run_r;
          end
          // The count reaches MAX_BUBBLE on this cycle (or already sits there).
          set_haz_s = (bubble_run_r >= BW'(MAX_BUBBLE - 1));
        end else begin
          bubble_run_nxt_s = {BW{1'b0}};
        end
      end

      MEM_WAIT: begin
        if (!mem_ack_i) begin
          pc_en_s    = 1'b0;
          fd_en_s    = 1'b0;
          dx_en_s    = 1'b0;
          xm_en_s    = 1'b0;
          mw_flush_s = 1'b1;
          if (tmo_cnt_r != TW'(MEM_TIMEOUT)) begin
            tmo_cnt_nxt_s = tmo_cnt_r + TW'(1);
          end else begin
            tmo_cnt_nxt_s = tmo_cnt_r;
          end
          set_tmo_s = (tmo_cnt_r >= TW'(MEM_TIMEOUT - 1));
        end else begin
          tmo_cnt_nxt_s = {TW{1'b0}};
          if (pending_flush_r) begin
            fd_flush_s          = 1'b1;
            dx_flush_s          = 1'b1;
            pending_flush_nxt_s = 1'b0;
            state_nxt_s         = FLUSH;
          end else begin
            state_nxt_s = RUN;
          end
        end
      end

      FLUSH: begin
        // dx holds a NOP this cycle, so bubble/branch requests are stale.
        if (hold_s) begin
          pc_en_s     = 1'b0;
          fd_en_s     = 1'b0;
          dx_en_s     = 1'b0;
          xm_en_s     = 1'b0;
          mw_flush_s  = 1'b1;
          state_nxt_s = MEM_WAIT;
        end else begin
          state_nxt_s = RUN;
        end
      end

      default: begin
        state_nxt_s = RUN;
      end
    endcase
  end

  // State and sticky-flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= RUN;
      pending_flush_r <= 1'b0;
      bubble_run_r    <= {BW{1'b0}};
      tmo_cnt_r       <= {TW{1'b0}};
      mem_timeout_r   <= 1'b0;
      hazard_err_r    <= 1'b0;
    end else begin
      state_r         <= state_nxt_s;
      pending_flush_r <= pending_flush_nxt_s;
      bubble_run_r    <= bubble_run_nxt_s;
      tmo_cnt_r       <= tmo_cnt_nxt_s;
      mem_timeout_r   <= mem_timeout_r | set_tmo_s;
      hazard_err_r    <= hazard_err_r | set_haz_s;
    end
  end

  // While reset is high every stage is frozen and loaded with NOPs.
  assign pc_en_o    = reset ? 1'b0 : pc_en_s;
  assign fd_en_o    = reset ? 1'b0 : fd_en_s;
  assign fd_flush_o = reset ? 1'b1 : fd_flush_s;
  assign dx_en_o    = reset ? 1'b0 : dx_en_s;
  assign dx_flush_o = reset ? 1'b1 : dx_flush_s;
  assign xm_en_o    = reset ? 1'b0 : xm_en_s;
  assign xm_flush_o = reset ? 1'b1 : xm_flush_s;
  assign mw_flush_o = reset ? 1'b1 : mw_flush_s;

  assign mem_timeout_o = mem_timeout_r;
  assign hazard_err_o  = hazard_err_r;

`ifdef STALL_COUNTER_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Stall-cycle counter; wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (!pc_en_o) begin
      stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cnt_o = stall_cnt_r;
`else
  assign stall_cnt_o = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Directed bench for pipeline_stall_ctrl. Each step drives one cycle of
// inputs and pushes the expected stage controls and flags into a scoreboard.
// The entry is then popped and compared on the falling edge.
//
// Packed output vector order:
//   {pc_en, fd_en, fd_flush, dx_en, dx_flush, xm_en, xm_flush, mw_flush}
// Flags order:
//   {mem_timeout, hazard_err}
// ---------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

  localparam int CNT_W = 32;

  localparam logic [7:0] V_ADV  = 8'b1101_0100;
  localparam logic [7:0] V_RST  = 8'b0010_1011;
  localparam logic [7:0] V_HOLD = 8'b0000_0001;
  localparam logic [7:0] V_BUB  = 8'b0000_0110;
  localparam logic [7:0] V_BR   = 8'b1111_1100;

`ifdef STALL_COUNTER_EN
  localparam logic [CNT_W-1:0] EXP_STALL_MEM = 32'd3;
`else
  localparam logic [CNT_W-1:0] EXP_STALL_MEM = 32'd0;
`endif

  logic clk = 1'b0;
  logic reset;
  logic bubble_i, branch_taken_i, mem_req_i, mem_ack_i;
  logic pc_en_o, fd_en_o, fd_flush_o, dx_en_o, dx_flush_o;
  logic xm_en_o, xm_flush_o, mw_flush_o;
  logic mem_timeout_o, hazard_err_o;
  logic [CNT_W-1:0] stall_cnt_o;

  logic [9:0] exp_q[$];
  string      tag_q[$];
  int         errors = 0;
  int         checks = 0;

  pipeline_stall_ctrl #(
    .MEM_TIMEOUT(16),
    .MAX_BUBBLE (2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .bubble_i      (bubble_i),
    .branch_taken_i(branch_taken_i),
    .mem_req_i     (mem_req_i),
    .mem_ack_i     (mem_ack_i),
    .pc_en_o       (pc_en_o),
    .fd_en_o       (fd_en_o),
    .fd_flush_o    (fd_flush_o),
    .dx_en_o       (dx_en_o),
    .dx_flush_o    (dx_flush_o),
    .xm_en_o       (xm_en_o),
    .xm_flush_o    (xm_flush_o),
    .mw_flush_o    (mw_flush_o),
    .mem_timeout_o (mem_timeout_o),
    .hazard_err_o  (hazard_err_o),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  // Drive one cycle of stimulus, queue its expectation, check at negedge.
  task automatic step(input string tag, input logic rst, input logic bub,
                      input logic br, input logic req, input logic ack,
                      input logic [7:0] ev, input logic [1:0] ef);
    logic [9:0] obs;
    logic [9:0] exp_v;
    string      t;
    reset          = rst;
    bubble_i       = bub;
    branch_taken_i = br;
    mem_req_i      = req;
    mem_ack_i      = ack;
    exp_q.push_back({ev, ef});
    tag_q.push_back(tag);
    @(negedge clk);
    obs   = {pc_en_o, fd_en_o, fd_flush_o, dx_en_o, dx_flush_o, xm_en_o,
             xm_flush_o, mw_flush_o, mem_timeout_o, hazard_err_o};
    exp_v = exp_q.pop_front();
    t     = tag_q.pop_front();
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", t, obs, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  // Compare the stall counter against a bench-side constant.
  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] exp_v);
    checks++;
    assert (stall_cnt_o === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, stall_cnt_o, exp_v);
    end
  endtask

  initial begin
    // Reset held three cycles, then the first free-running cycle.
    for (int i = 0; i < 3; i++) step("reset_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, V_RST, 2'b00);
    check_cnt("stall_cnt_reset", 32'd0);
    step("first_run", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b00);

    // Memory access acked three cycles after the request.
    step("mem_req",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b00);
    step("mem_wait1", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b00);
    step("mem_wait2", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b00);
    step("mem_ack",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_ADV,  2'b00);
    step("mem_after", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV,  2'b00);
    check_cnt("stall_cnt_mem", EXP_STALL_MEM);

    // Single-cycle access: request and ack together, no stall.
    step("mem_1cyc",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_ADV, 2'b00);

    // Single bubble, then two consecutive bubbles trip the hazard flag.
    step("bub_one",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BUB, 2'b00);
    step("bub_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b00);
    step("bub_two_a", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BUB, 2'b00);
    step("bub_two_b", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BUB, 2'b00);
    step("haz_set",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b01);
    step("haz_stick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b01);

    // Branch under a memory stall is replayed as a flush on the ack.
    step("mbr_req",   1'b0, 1'b0, 1'b1, 1'b1, 1'b0, V_HOLD, 2'b01);
    step("mbr_wait",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b01);
    step("mbr_ack",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_BR,   2'b01);
    step("mbr_flush", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV,  2'b01);
    // Pending flush must be gone: a plain access completes without a flush.
    step("mbr_req2",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b01);
    step("mbr_ack2",  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_ADV,  2'b01);

    // Branch beats bubble; the bubble in the FLUSH cycle is ignored.
    step("brb_both",  1'b0, 1'b1, 1'b1, 1'b0, 1'b0, V_BR,  2'b01);
    step("brb_flush", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_ADV, 2'b01);
    step("brb_run",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b01);

    // A memory stall raised during FLUSH goes straight to MEM_WAIT.
    step("fm_branch", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, V_BR,   2'b01);
    step("fm_req",    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b01);
    step("fm_wait",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b01);
    step("fm_ack",    1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_ADV,  2'b01);

    // Ack withheld 20 cycles: the flag is visible after 16 MEM_WAIT cycles.
    for (int i = 0; i < 20; i++) begin
      step("tmo_wait", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD,
           {((i >= 17) ? 1'b1 : 1'b0), 1'b1});
    end
    step("tmo_ack",   1'b0, 1'b0, 1'b0, 1'b1, 1'b1, V_ADV, 2'b11);
    step("tmo_stick", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b11);

    // Reset asserted in the middle of a memory wait.
    step("rmw_req",   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b11);
    step("rmw_wait",  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, V_HOLD, 2'b11);
    step("rmw_reset", 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, V_RST,  2'b11);
    check_cnt("stall_cnt_rst2", 32'd0);
    // Idle with no ack advances, so the FSM is back in RUN.
    step("rmw_run",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b00);
    step("rmw_bub",   1'b0, 1'b1, 1'b0, 1'b0, 1'b0, V_BUB, 2'b00);
    step("rmw_end",   1'b0, 1'b0, 1'b0, 1'b0, 1'b0, V_ADV, 2'b00);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
